sk_unpack_stream: RTL and testbench

SK_UNPACK_STREAM -- requirements
Module: sk_unpack_stream

---
 rtl/sk_unpack_pkg.sv | 28 ++
 rtl/sk_unpack_stream_if.sv | 24 ++
 rtl/sk_bit_accum.sv | 50 +++++
 rtl/sk_unpack_stream.sv | 165 ++++++++++++++++
 tb/tb_sk_unpack_stream.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sk_unpack_pkg.sv
// Shared constants, section/state encodings and the eta field-width mapping
// for the secret-key unpacker.
package sk_unpack_pkg;

    localparam int unsigned N          = 256;
    localparam int unsigned D          = 13;
    localparam int unsigned SEED_BYTES = 128;

    typedef enum logic [1:0] {
        SEC_S1 = 2'd0,
        SEC_S2 = 2'd1,
        SEC_T0 = 2'd2
    } sec_e;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        S1,
        S2,
        T0,
        DONE
    } state_e;

    function automatic int unsigned eta_to_ew(input int unsigned eta);
        return (eta == 2) ? 3 : 4;
    endfunction

endpackage

// File: rtl/sk_unpack_stream_if.sv
// Byte input stream and tagged coefficient output stream of the unpacker.
interface sk_unpack_stream_if;

    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] coef_out;
    logic        coef_valid;
    logic        coef_ready;
    logic [1:0]  coef_sec;
    logic [2:0]  coef_poly;
    logic [7:0]  coef_idx;

    modport slave (
        input  in_byte, in_valid, coef_ready,
        output in_ready, coef_out, coef_valid, coef_sec, coef_poly, coef_idx
    );

    modport master (
        output in_byte, in_valid, coef_ready,
        input  in_ready, coef_out, coef_valid, coef_sec, coef_poly, coef_idx
    );

endinterface

// File: rtl/sk_bit_accum.sv
// LSB-first bit accumulator: bytes are appended above the held bits, fields
// are removed from the bottom. A byte pushed in the same cycle as a pop is
// visible to that pop, which keeps one field per cycle with a steady feed.
module sk_bit_accum #(
    parameter int unsigned AW = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [7:0]  push_byte,
    input  logic        pop,
    input  logic [3:0]  pop_w,
    output logic [12:0] peek,
    output logic [5:0]  avail,
    output logic [5:0]  count
);

    logic [AW-1:0] acc;
    logic [AW-1:0] merged;

    // Merge the incoming byte at the current fill level.
    always_comb begin
        merged = acc;
        avail  = count;
        if (push) begin
            merged = acc | (AW'(push_byte) << count);
            avail  = count + 6'd8;
        end
        peek = merged[12:0];
    end

    // Storage update: pop shifts the merged word down by the field width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else if (flush) begin
            acc   <= '0;
            count <= '0;
        end else if (pop) begin
            acc   <= merged >> pop_w;
            count <= avail - {2'b00, pop_w};
        end else begin
            acc   <= merged;
            count <= avail;
        end
    end

endmodule

// File: rtl/sk_unpack_stream.sv
// Streaming secret-key unpacker: captures the 128-byte seed block, then
// slices s1, s2 and t0 coefficients out of the byte stream with a tagged
// valid/ready output.
module sk_unpack_stream
    import sk_unpack_pkg::*;
#(
    parameter int unsigned K   = 6,
    parameter int unsigned L   = 5,
    parameter int unsigned ETA = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    sk_unpack_stream_if.slave bus,
    output logic [255:0]      rho_out,
    output logic [255:0]      key_out,
    output logic [511:0]      tr_out,
    output logic              seed_valid,
    output logic              coef_err,
    output logic              busy,
    output logic              done
);

    localparam int unsigned EW  = eta_to_ew(ETA);
    localparam logic [3:0]  W_S = 4'(EW);
    localparam logic [3:0]  W_T = 4'(D);

    state_e        state, state_nxt;
    sec_e          sec_cur;
    logic [1023:0] seed_sr;
    logic [6:0]    seed_cnt;
    logic [7:0]    ld_idx;
    logic [2:0]    ld_poly;
    logic          ld_done;
    logic          in_sec, in_hs, coef_hs, out_free, start_acc;
    logic          load, ld_last_poly, ld_last, field_bad;
    logic [3:0]    w_cur;
    logic [12:0]   peek, field;
    logic [5:0]    avail, count;
    logic [31:0]   coef_nxt;

    assign rho_out = seed_sr[255:0];
    assign key_out = seed_sr[511:256];
    assign tr_out  = seed_sr[1023:512];
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // Handshakes, field extraction and coefficient arithmetic.
    always_comb begin
        in_sec       = (state == S1) || (state == S2) || (state == T0);
        w_cur        = (state == T0) ? W_T : W_S;
        sec_cur      = (state == T0) ? SEC_T0 : ((state == S2) ? SEC_S2 : SEC_S1);
        bus.in_ready = (state == SEED) ||
                       (in_sec && !ld_done && (count < {2'b00, w_cur}));
        in_hs        = bus.in_valid && bus.in_ready;
        coef_hs      = bus.coef_valid && bus.coef_ready;
        out_free     = !bus.coef_valid || bus.coef_ready;
        start_acc    = (state == IDLE) && start;
        load         = in_sec && !ld_done && out_free && (avail >= {2'b00, w_cur});
        field        = peek & ((13'd1 << w_cur) - 13'd1);
        ld_last_poly = (state == S1) ? (ld_poly == 3'(L - 1)) : (ld_poly == 3'(K - 1));
        ld_last      = ld_last_poly && (ld_idx == 8'(N - 1));
        field_bad    = (state != T0) && (field > 13'(2 * ETA));
        coef_nxt     = (state == T0) ? (32'(1 << (D - 1)) - {19'd0, field})
                                     : (32'(ETA) - {19'd0, field});
    end

    sk_bit_accum #(.AW(24)) u_accum (
        .clk       (clk),
        .rst       (rst),
        .flush     (start_acc),
        .push      (in_hs && in_sec),
        .push_byte (bus.in_byte),
        .pop       (load),
        .pop_w     (w_cur),
        .peek      (peek),
        .avail     (avail),
        .count     (count)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; section changes happen when the last field of a section
    // is loaded, DONE waits for the final t0 handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SEED;
            SEED: if (in_hs && (seed_cnt == 7'(SEED_BYTES - 1))) state_nxt = S1;
            S1:   if (load && ld_last) state_nxt = S2;
            S2:   if (load && ld_last) state_nxt = T0;
            T0:   if (ld_done && coef_hs) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Seed capture: bytes shift in from the top so byte 0 ends in bits [7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_sr    <= '0;
            seed_cnt   <= '0;
            seed_valid <= 1'b0;
        end else begin
            if (start_acc) begin
                seed_cnt   <= '0;
                seed_valid <= 1'b0;
            end
            if ((state == SEED) && in_hs) begin
                seed_sr  <= {bus.in_byte, seed_sr[1023:8]};
                seed_cnt <= seed_cnt + 7'd1;
                if (seed_cnt == 7'(SEED_BYTES - 1)) seed_valid <= 1'b1;
            end
        end
    end

    // Output register, tag counters and sticky range error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.coef_valid <= 1'b0;
            bus.coef_out   <= '0;
            bus.coef_sec   <= '0;
            bus.coef_poly  <= '0;
            bus.coef_idx   <= '0;
            coef_err       <= 1'b0;
            ld_idx         <= '0;
            ld_poly        <= '0;
            ld_done        <= 1'b0;
        end else begin
            if (start_acc) begin
                coef_err <= 1'b0;
                ld_idx   <= '0;
                ld_poly  <= '0;
                ld_done  <= 1'b0;
            end
            if (coef_hs) bus.coef_valid <= 1'b0;
            if (load) begin
                bus.coef_valid <= 1'b1;
                bus.coef_out   <= coef_nxt;
                bus.coef_sec   <= sec_cur;
                bus.coef_poly  <= ld_poly;
                bus.coef_idx   <= ld_idx;
                if (field_bad) coef_err <= 1'b1;
                ld_idx <= ld_idx + 8'd1;
                if (ld_idx == 8'(N - 1)) begin
                    if (ld_last_poly) begin
                        ld_poly <= '0;
                        if (state == T0) ld_done <= 1'b1;
                    end else begin
                        ld_poly <= ld_poly + 3'd1;
                    end
                end
            end
        end
    end

    // Sections are byte aligned: the last field of a section empties the accumulator.
    assert property (@(posedge clk) disable iff (rst)
                     (load && ld_last) |-> (avail == {2'b00, w_cur}));

endmodule

// File: tb/tb_sk_unpack_stream.sv
// Directed bench for sk_unpack_stream: a bit-level model builds the expected
// coefficient sequence for each key and a scoreboard checks every handshake.
module tb_sk_unpack_stream;
    import sk_unpack_pkg::*;

    typedef struct {
        logic [1:0]  sec;
        logic [2:0]  poly;
        logic [7:0]  idx;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, in_valid, coef_ready;
    logic [7:0] in_byte;
    int   sel;
    logic start0, start1;

    always #5 clk = ~clk;

    sk_unpack_stream_if bus0 ();
    sk_unpack_stream_if bus1 ();

    assign bus0.in_byte    = in_byte;
    assign bus0.in_valid   = in_valid;
    assign bus0.coef_ready = coef_ready;
    assign bus1.in_byte    = in_byte;
    assign bus1.in_valid   = in_valid;
    assign bus1.coef_ready = coef_ready;
    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);

    logic [255:0] rho0, key0, rho1, key1;
    logic [511:0] tr0, tr1;
    logic sv0, err0, busy0, done0, sv1, err1, busy1, done1;

    sk_unpack_stream #(.K(6), .L(5), .ETA(4)) dut (
        .clk(clk), .rst(rst), .start(start0), .bus(bus0),
        .rho_out(rho0), .key_out(key0), .tr_out(tr0), .seed_valid(sv0),
        .coef_err(err0), .busy(busy0), .done(done0)
    );

    sk_unpack_stream #(.K(4), .L(4), .ETA(2)) dut2 (
        .clk(clk), .rst(rst), .start(start1), .bus(bus1),
        .rho_out(rho1), .key_out(key1), .tr_out(tr1), .seed_valid(sv1),
        .coef_err(err1), .busy(busy1), .done(done1)
    );

    logic        o_ready, o_cv, o_sv, o_err, o_busy, o_done;
    logic [31:0] o_cout;
    logic [1:0]  o_sec;
    logic [2:0]  o_poly;
    logic [7:0]  o_idx;
    logic [255:0] o_rho, o_key;
    logic [511:0] o_tr;

    always_comb begin
        if (sel == 0) begin
            o_ready = bus0.in_ready; o_cv = bus0.coef_valid; o_cout = bus0.coef_out;
            o_sec = bus0.coef_sec; o_poly = bus0.coef_poly; o_idx = bus0.coef_idx;
            o_sv = sv0; o_err = err0; o_busy = busy0; o_done = done0;
            o_rho = rho0; o_key = key0; o_tr = tr0;
        end else begin
            o_ready = bus1.in_ready; o_cv = bus1.coef_valid; o_cout = bus1.coef_out;
            o_sec = bus1.coef_sec; o_poly = bus1.coef_poly; o_idx = bus1.coef_idx;
            o_sv = sv1; o_err = err1; o_busy = busy1; o_done = done1;
            o_rho = rho1; o_key = key1; o_tr = tr1;
        end
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]   kbytes[$];
    exp_t         exp_q[$];
    logic         exp_err;
    int           exp_total;
    logic [255:0] exp_rho, exp_key;
    logic [511:0] exp_tr;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 zeros, 1 all 0xFF, 2 random, 3 random with first s1 byte 0xFA
    task automatic prep_key(input int kind);
        int k, l, eta, ew, w, npoly, bitpos, field;
        logic [7:0] b;
        exp_t e;
        k   = (sel == 1) ? 4 : 6;
        l   = (sel == 1) ? 4 : 5;
        eta = (sel == 1) ? 2 : 4;
        ew  = (eta == 2) ? 3 : 4;
        exp_total = 128 + (l + k) * 32 * ew + k * 416;
        kbytes.delete();
        exp_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < exp_total; i++) begin
            case (kind)
                0:       kbytes.push_back(8'h00);
                1:       kbytes.push_back(8'hFF);
                default: kbytes.push_back(8'($urandom_range(0, 255)));
            endcase
        end
        if (kind == 3) kbytes[128] = 8'hFA;
        for (int i = 0; i < 32; i++) begin
            exp_rho[i*8 +: 8] = kbytes[i];
            exp_key[i*8 +: 8] = kbytes[32 + i];
        end
        for (int i = 0; i < 64; i++) exp_tr[i*8 +: 8] = kbytes[64 + i];
        bitpos = 0;
        for (int s = 0; s < 3; s++) begin
            npoly = (s == 0) ? l : k;
            w     = (s == 2) ? 13 : ew;
            for (int p = 0; p < npoly; p++) begin
                for (int i = 0; i < 256; i++) begin
                    field = 0;
                    for (int bb = 0; bb < w; bb++) begin
                        b = kbytes[128 + bitpos / 8];
                        if (b[bitpos % 8]) field = field | (1 << bb);
                        bitpos++;
                    end
                    e.sec  = 2'(s);
                    e.poly = 3'(p);
                    e.idx  = 8'(i);
                    e.val  = (s == 2) ? 32'(4096 - field) : 32'(eta - field);
                    if ((s < 2) && (field > 2 * eta)) exp_err = 1'b1;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic run_key(input bit gaps, input bit stall, input bit glitch,
                           input bit abort, input bit tp);
        int   bptr = 0, cyc = 0, done_cnt = 0, post = -1, stall_left = 0;
        int   s_first = -1, s_last = 0, s_n = 0;
        bit   sv_flag = 0, stalled = 0, glitched = 0, aborted = 0, hold_pend = 0;
        logic [45:0] held = '0;
        exp_t e;

        @(posedge clk); #1;
        in_valid = 1'b1; in_byte = 8'hA5; coef_ready = 1'b1;
        @(negedge clk);
        check("idle_ready", o_ready, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; in_byte = kbytes[0];

        while (cyc < 20000) begin
            @(negedge clk);
            if (hold_pend) check("hold", {o_cv, o_sec, o_poly, o_idx, o_cout}, held);
            hold_pend = o_cv && !coef_ready;
            held      = {o_cv, o_sec, o_poly, o_idx, o_cout};
            if (in_valid && o_ready) begin
                if (bptr == 127) begin
                    check("seed_valid_pre", o_sv, 1'b0);
                    sv_flag = 1;
                end
                bptr++;
            end
            if (o_cv && coef_ready) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else begin e.sec = 2'd3; e.poly = 3'd7; e.idx = 8'hFF; e.val = 32'hDEAD_BEEF; end
                check("coef", {o_sec, o_poly, o_idx, o_cout}, {e.sec, e.poly, e.idx, e.val});
                if (o_sec != 2'd2) begin
                    if (s_first < 0) s_first = cyc;
                    s_last = cyc;
                    s_n++;
                end
            end
            if (o_done) done_cnt++;
            if (post == 0) break;
            if (post > 0) post--;
            else if (done_cnt > 0) post = 3;

            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (sv_flag) begin
                check("seed_valid_rise", o_sv, 1'b1);
                sv_flag = 0;
            end
            if (abort && !aborted && o_cv && (o_sec == 2'd2) && (o_poly == 3'd2)) begin
                rst = 1'b1;
                #1;
                check("rst_ctl", {o_cv, o_err, o_busy, o_done, o_ready, o_sv}, '0);
                check("rst_coef", {o_cout, o_sec, o_poly, o_idx}, '0);
                check("rst_rho_key", {o_rho, o_key}, '0);
                check("rst_tr", o_tr, '0);
                aborted = 1;
                break;
            end
            if (glitch && !glitched && o_cv && (o_sec == 2'd0) && (o_idx == 8'd50)) begin
                start = 1'b1;
                glitched = 1;
                check("busy_glitch", o_busy, 1'b1);
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    check("stall_in_ready", o_ready, 1'b0);
                    coef_ready = 1'b1;
                end
            end else if (stall && !stalled && o_cv && (o_sec == 2'd1) &&
                         (o_poly == 3'd3) && (o_idx == 8'd17)) begin
                stalled = 1; stall_left = 10; coef_ready = 1'b0;
            end else begin
                coef_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (bptr < kbytes.size()) begin
                in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_byte  = kbytes[bptr];
            end else begin
                in_valid = 1'b0;
                in_byte  = 8'h00;
            end
        end

        in_valid = 1'b0;
        coef_ready = 1'b1;
        if (abort) begin
            check("abort_reached", aborted, 1'b1);
            @(negedge clk);
            rst = 1'b0;
            exp_q.delete();
            return;
        end
        check("done_seen", done_cnt > 0, 1'b1);
        check("done_once", done_cnt, 1);
        check("busy_end", o_busy, 1'b0);
        check("sv_held", o_sv, 1'b1);
        check("ready_idle", o_ready, 1'b0);
        check("coef_err", o_err, exp_err);
        check("sb_empty", exp_q.size(), 0);
        check("bytes", bptr, exp_total);
        check("rho", o_rho, exp_rho);
        check("key", o_key, exp_key);
        check("tr", o_tr, exp_tr);
        if (stall) check("stall_done", stalled, 1'b1);
        if (glitch) check("glitch_done", glitched, 1'b1);
        if (tp) check("s_throughput", s_last - s_first, s_n - 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = '0; coef_ready = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {o_cv, o_err, o_busy, o_done, o_ready, o_sv}, '0);
        check("reset_coef", {o_cout, o_sec, o_poly, o_idx}, '0);
        check("reset_seed", {o_rho, o_key}, '0);
        rst = 1'b0;

        sel = 0; prep_key(0); run_key(0, 0, 0, 0, 1);
        check("zero_total", exp_total, 4032);
        sel = 0; prep_key(1); run_key(0, 0, 0, 0, 1);
        sel = 0; prep_key(2); run_key(0, 1, 1, 0, 0);
        sel = 0; prep_key(2); run_key(1, 0, 0, 1, 0);
        sel = 0; prep_key(2); run_key(1, 0, 0, 0, 0);
        sel = 1; prep_key(3); run_key(0, 0, 0, 0, 1);
        check("small_total", exp_total, 2560);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
